// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and memory, with memory wait states, a mul/div stall and a trap path.
module multicycle_controller #(
  parameter int MEM_WAIT_CYCLES = 0,
  parameter int MULDIV_CYCLES   = 8,
  parameter bit EXC_ENABLE      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       BranchCond,
  input  logic       Interrupt,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       EPCWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic       MulDivStart,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] Branch,
  output logic [3:0] ALUOp,
  output logic [1:0] Cause
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEMACC = 3'd3;
  localparam logic [2:0] WBACK  = 3'd4;
  localparam logic [2:0] MULDIV = 3'd5;
  localparam logic [2:0] TRAP   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] WAIT_LAST   = 6'(MEM_WAIT_CYCLES);
  localparam logic [5:0] MULDIV_LAST = 6'(MULDIV_CYCLES - 1);

  logic [2:0] state, nextState;
  logic [5:0] waitCnt;
  logic [1:0] trapCause;
  logic       pcWriteRaw, irWriteRaw, epcWriteRaw, memWriteRaw, regWriteRaw, mulDivStartRaw;
  logic       isRType, isBranch, isShift, isMulDiv, isJr, isJalr, isLw, isSw, isLui, legal;
  logic       waitLast, irqTake;

  function automatic logic isLegal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE)
      return fn inside {[6'h20:6'h27], 6'h00, 6'h02, 6'h03, 6'h2a, 6'h2b,
                        6'h08, 6'h09, [6'h18:6'h1b]};
    return op inside {OP_LW, OP_SW, OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
                      OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
                      OP_BLTZ, OP_J, OP_JAL};
  endfunction

  assign isRType  = (OpCode == OP_RTYPE);
  assign isBranch = OpCode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ};
  assign isShift  = isRType && (Funct inside {6'h00, 6'h02, 6'h03});
  assign isMulDiv = isRType && (Funct inside {[6'h18:6'h1b]});
  assign isJr     = isRType && (Funct == 6'h08);
  assign isJalr   = isRType && (Funct == 6'h09);
  assign isLw     = (OpCode == OP_LW);
  assign isSw     = (OpCode == OP_SW);
  assign isLui    = (OpCode == OP_LUI);
  assign legal    = isLegal(OpCode, Funct);
  assign waitLast = (waitCnt == WAIT_LAST);
  // Interrupt is only looked at on the first fetch cycle so in-flight work completes.
  assign irqTake  = EXC_ENABLE && !reset && (state == FETCH) && (waitCnt == 6'd0) && Interrupt;

  always_comb begin
    nextState      = state;
    trapCause      = 2'b00;
    pcWriteRaw     = 1'b0;
    irWriteRaw     = 1'b0;
    epcWriteRaw    = 1'b0;
    memWriteRaw    = 1'b0;
    regWriteRaw    = 1'b0;
    mulDivStartRaw = 1'b0;
    MemRead        = 1'b0;
    IorD           = 1'b0;
    ExtOp          = 1'b0;
    LuiOp          = 1'b0;
    MemtoReg       = 2'b00;
    RegDst         = 2'b00;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    PCSource       = 2'b00;
    Branch         = 3'b000;
    ALUOp          = 4'b0000;
    case (state)
      FETCH: begin
        if (irqTake) begin
          nextState = TRAP;
          trapCause = 2'b01;
        end else begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (waitLast) begin
            irWriteRaw = 1'b1;
            pcWriteRaw = 1'b1;
            nextState  = DECODE;
          end
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (!legal) begin
          nextState = EXC_ENABLE ? TRAP : FETCH;
          trapCause = EXC_ENABLE ? 2'b10 : 2'b00;
        end else if (OpCode == OP_J || OpCode == OP_JAL || isJr || isJalr) begin
          pcWriteRaw = 1'b1;
          PCSource   = 2'b10;
          nextState  = FETCH;
          if (OpCode == OP_JAL || isJalr) begin
            regWriteRaw = 1'b1;
            RegDst      = isJalr ? 2'b01 : 2'b10;
            MemtoReg    = 2'b10;
          end
        end else if (isMulDiv) begin
          nextState = MULDIV;
        end else begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        ALUOp[3] = OpCode[0];
        if (isRType) ALUOp[2:0] = 3'b010;
        else begin
          case (OpCode)
            OP_BEQ:            ALUOp[2:0] = 3'b001;
            OP_ANDI:           ALUOp[2:0] = 3'b100;
            OP_ORI:            ALUOp[2:0] = 3'b011;
            OP_SLTI, OP_SLTIU: ALUOp[2:0] = 3'b101;
            default:           ALUOp[2:0] = 3'b000;
          endcase
        end
        ALUSrcA = isShift ? 2'b10 : 2'b01;
        ALUSrcB = (isRType || isBranch) ? 2'b00 : 2'b10;
        ExtOp   = !isShift;
        LuiOp   = isLui;
        if (isBranch) begin
          Branch     = OpCode[2:0];
          pcWriteRaw = BranchCond;
          PCSource   = 2'b01;
          nextState  = FETCH;
        end else begin
          nextState = (isLw || isSw) ? MEMACC : WBACK;
        end
      end
      MEMACC: begin
        IorD        = 1'b1;
        MemRead     = isLw;
        memWriteRaw = isSw;
        if (waitLast) nextState = isLw ? WBACK : FETCH;
      end
      WBACK: begin
        regWriteRaw = 1'b1;
        MemtoReg    = isLw ? 2'b00 : 2'b01;
        RegDst      = isRType ? 2'b01 : 2'b00;
        nextState   = FETCH;
      end
      MULDIV: begin
        mulDivStartRaw = (waitCnt == 6'd0);
        if (waitCnt == MULDIV_LAST) nextState = FETCH;
      end
      TRAP: begin
        epcWriteRaw = 1'b1;
        pcWriteRaw  = 1'b1;
        PCSource    = 2'b11;
        nextState   = FETCH;
      end
      default: nextState = FETCH;
    endcase
  end

  // State-changing strobes are suppressed while reset is held so an aborted instruction leaves no trace.
  assign PCWrite     = pcWriteRaw & ~reset;
  assign IRWrite     = irWriteRaw & ~reset;
  assign EPCWrite    = epcWriteRaw & ~reset;
  assign MemWrite    = memWriteRaw & ~reset;
  assign RegWrite    = regWriteRaw & ~reset;
  assign MulDivStart = mulDivStartRaw & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      waitCnt <= 6'd0;
      Cause   <= 2'b00;
    end else begin
      state   <= nextState;
      waitCnt <= (nextState != state) ? 6'd0 : waitCnt + 6'd1;
      if (nextState == TRAP && state != TRAP) Cause <= trapCause;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: three instances (W=0, W=2, no-exceptions)
// driven by shared directed stimulus, one instance checked per expectation.
module tb_multicycle_controller;

  typedef struct packed {
    logic pcw, irw, epc, mr, mw, rw, iord, ext, lui, mds;
    logic [1:0] m2r, rd, asa, asb, pcs;
    logic [2:0] br;
    logic [3:0] aluop;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    string       nm;
    int          sel;
    logic [28:0] exp;
    logic [28:0] msk;
  } item_t;

  localparam logic [28:0] FULL       = 29'h1FFF_FFFF;
  localparam logic [28:0] MASK_NOASB = 29'h1FFF_E7FF;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] OpCode, Funct;
  logic BranchCond, Interrupt;

  logic pcw [3], irw [3], epc [3], mr [3], mw [3], rw [3], iord [3], ext [3], lui [3], mds [3];
  logic [1:0] m2r [3], rd [3], asa [3], asb [3], pcs [3], cause [3];
  logic [2:0] br [3];
  logic [3:0] aluop [3];
  logic [28:0] outv [3];

  item_t q[$];
  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gDut
      multicycle_controller #(
        .MEM_WAIT_CYCLES(g == 1 ? 2 : 0),
        .MULDIV_CYCLES(8),
        .EXC_ENABLE(g == 2 ? 1'b0 : 1'b1)
      ) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .BranchCond(BranchCond), .Interrupt(Interrupt),
        .PCWrite(pcw[g]), .IRWrite(irw[g]), .EPCWrite(epc[g]), .MemRead(mr[g]),
        .MemWrite(mw[g]), .RegWrite(rw[g]), .IorD(iord[g]), .ExtOp(ext[g]),
        .LuiOp(lui[g]), .MulDivStart(mds[g]), .MemtoReg(m2r[g]), .RegDst(rd[g]),
        .ALUSrcA(asa[g]), .ALUSrcB(asb[g]), .PCSource(pcs[g]), .Branch(br[g]),
        .ALUOp(aluop[g]), .Cause(cause[g])
      );
      assign outv[g] = {pcw[g], irw[g], epc[g], mr[g], mw[g], rw[g], iord[g], ext[g],
                        lui[g], mds[g], m2r[g], rd[g], asa[g], asb[g], pcs[g], br[g],
                        aluop[g], cause[g]};
    end
  endgenerate

  // Monitor: one expectation per cycle in which the stimulus queued one.
  always @(negedge clk) begin
    item_t it;
    logic [28:0] act;
    if (q.size() > 0) begin
      it = q.pop_front();
      act = outv[it.sel];
      nChecks++;
      if ((act & it.msk) !== (it.exp & it.msk)) begin
        nFail++;
        $display("FAIL %s (dut%0d): got %h, expected %h (mask %h)", it.nm, it.sel, act, it.exp, it.msk);
      end
    end
  end

  function automatic ctl_t fetchE(input bit last, input logic [1:0] c);
    ctl_t e = '0;
    e.mr = 1'b1; e.asb = 2'b01; e.pcw = last; e.irw = last; e.cause = c;
    return e;
  endfunction

  function automatic ctl_t decodeE(input logic [1:0] c);
    ctl_t e = '0;
    e.asb = 2'b11; e.cause = c;
    return e;
  endfunction

  function automatic ctl_t trapE(input logic [1:0] c);
    ctl_t e = '0;
    e.epc = 1'b1; e.pcw = 1'b1; e.pcs = 2'b11; e.cause = c;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string nm, input int sel, input ctl_t e, input logic [28:0] m);
    item_t it;
    it.nm = nm; it.sel = sel; it.exp = e; it.msk = m;
    q.push_back(it);
    tick();
  endtask

  task automatic fetchW2(input string nm, input logic [1:0] c);
    cyc(nm, 1, fetchE(1'b0, c), MASK_NOASB);
    cyc(nm, 1, fetchE(1'b0, c), MASK_NOASB);
    cyc(nm, 1, fetchE(1'b1, c), FULL);
  endtask

  task automatic doReset();
    reset = 1'b1; Interrupt = 1'b0; BranchCond = 1'b0;
    for (int s = 0; s < 3; s++) cyc("resetState", s, fetchE(1'b0, 2'b00), FULL);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    ctl_t e;
    reset = 1'b1; OpCode = 6'h00; Funct = 6'h00; BranchCond = 1'b0; Interrupt = 1'b0;
    tick();
    doReset();

    // ---- dut0 (W=0): add, sll, jal, beq, bne, illegal, mult + interrupt
    OpCode = 6'h00; Funct = 6'h20;
    cyc("addFetch", 0, fetchE(1'b1, 2'b00), FULL);
    cyc("addDecode", 0, decodeE(2'b00), FULL);
    e = '0; e.aluop = 4'b0010; e.asa = 2'b01; e.ext = 1'b1;
    cyc("addExec", 0, e, FULL);
    e = '0; e.rw = 1'b1; e.m2r = 2'b01; e.rd = 2'b01;
    cyc("addWback", 0, e, FULL);

    Funct = 6'h00;
    cyc("sllFetch", 0, fetchE(1'b1, 2'b00), FULL);
    cyc("sllDecode", 0, decodeE(2'b00), FULL);
    e = '0; e.aluop = 4'b0010; e.asa = 2'b10;
    cyc("sllExec", 0, e, FULL);
    e = '0; e.rw = 1'b1; e.m2r = 2'b01; e.rd = 2'b01;
    cyc("sllWback", 0, e, FULL);

    OpCode = 6'h03;
    cyc("jalFetch", 0, fetchE(1'b1, 2'b00), FULL);
    e = decodeE(2'b00); e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10;
    cyc("jalDecode", 0, e, FULL);

    OpCode = 6'h04; BranchCond = 1'b1;
    cyc("beqFetch", 0, fetchE(1'b1, 2'b00), FULL);
    cyc("beqDecode", 0, decodeE(2'b00), FULL);
    e = '0; e.aluop = 4'b0001; e.asa = 2'b01; e.ext = 1'b1; e.br = 3'b100; e.pcw = 1'b1; e.pcs = 2'b01;
    cyc("beqExec", 0, e, FULL);

    OpCode = 6'h05; BranchCond = 1'b0;
    cyc("bneFetch", 0, fetchE(1'b1, 2'b00), FULL);
    cyc("bneDecode", 0, decodeE(2'b00), FULL);
    e = '0; e.aluop = 4'b1000; e.asa = 2'b01; e.ext = 1'b1; e.br = 3'b101; e.pcs = 2'b01;
    cyc("bneExec", 0, e, FULL);

    OpCode = 6'h3f; Funct = 6'h00;
    cyc("illFetch", 0, fetchE(1'b1, 2'b00), FULL);
    cyc("illDecode", 0, decodeE(2'b00), FULL);
    cyc("illTrap", 0, trapE(2'b10), FULL);

    OpCode = 6'h00; Funct = 6'h18;
    cyc("multFetch", 0, fetchE(1'b1, 2'b10), FULL);
    cyc("multDecode", 0, decodeE(2'b10), FULL);
    e = '0; e.mds = 1'b1; e.cause = 2'b10;
    cyc("multStart", 0, e, FULL);
    e = '0; e.cause = 2'b10;
    for (int i = 1; i < 8; i++) begin
      if (i == 3) Interrupt = 1'b1;
      cyc("multStall", 0, e, FULL);
    end
    e = '0; e.cause = 2'b10;
    cyc("irqFetch", 0, e, MASK_NOASB);
    Interrupt = 1'b0;
    cyc("irqTrap", 0, trapE(2'b01), FULL);
    cyc("postTrapFetch", 0, fetchE(1'b1, 2'b01), FULL);

    // ---- dut2 (EXC_ENABLE=0): illegal runs as nop, interrupt ignored
    doReset();
    OpCode = 6'h3f; Funct = 6'h00;
    cyc("nopFetch", 2, fetchE(1'b1, 2'b00), FULL);
    cyc("nopDecode", 2, decodeE(2'b00), FULL);
    Interrupt = 1'b1;
    cyc("nopBackToFetch", 2, fetchE(1'b1, 2'b00), FULL);
    Interrupt = 1'b0;

    // ---- dut1 (W=2): interrupt trap, lw, sw aborted by reset
    doReset();
    Interrupt = 1'b1; OpCode = 6'h23;
    e = '0;
    cyc("w2IrqFetch", 1, e, MASK_NOASB);
    Interrupt = 1'b0;
    cyc("w2IrqTrap", 1, trapE(2'b01), FULL);
    fetchW2("lwFetch", 2'b01);
    cyc("lwDecode", 1, decodeE(2'b01), FULL);
    e = '0; e.aluop = 4'b1000; e.asa = 2'b01; e.asb = 2'b10; e.ext = 1'b1; e.cause = 2'b01;
    cyc("lwExec", 1, e, FULL);
    e = '0; e.iord = 1'b1; e.mr = 1'b1; e.cause = 2'b01;
    for (int i = 0; i < 3; i++) cyc("lwMemacc", 1, e, FULL);
    e = '0; e.rw = 1'b1; e.cause = 2'b01;
    cyc("lwWback", 1, e, FULL);

    OpCode = 6'h2b;
    fetchW2("swFetch", 2'b01);
    cyc("swDecode", 1, decodeE(2'b01), FULL);
    e = '0; e.aluop = 4'b1000; e.asa = 2'b01; e.asb = 2'b10; e.ext = 1'b1; e.cause = 2'b01;
    cyc("swExec", 1, e, FULL);
    e = '0; e.iord = 1'b1; e.mw = 1'b1; e.cause = 2'b01;
    cyc("swMemacc", 1, e, FULL);
    reset = 1'b1;
    cyc("swResetAbort", 1, fetchE(1'b0, 2'b00), FULL);
    reset = 1'b0;
    fetchW2("swPostReset", 2'b00);

    tick();
    tick();
    nChecks++;
    if (q.size() != 0) begin
      nFail++;
      $display("FAIL scoreboardDrain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
